lag_measure: RTL and testbench

- Measures the lag from the video start flash to the light sensor firing, at 0.1 ms resolution.
- Keeps the current, minimum, maximum and 16-sample average values, and presents them as 5-digit packed BCD for the on-screen text generator.
- Sits between the sensor conditioner / start-flag crossing (upstream) and the BCD data-crossing into the pixel domain (downstream).
- Runs entirely in the 27 MHz system clock domain.

---
 rtl/lag_measure_pkg.sv | 29 ++
 rtl/lag_measure_bin2bcd_seq.sv | 37 +++
 rtl/lag_measure.sv | 178 +++++++++++++++++
 tb/tb_lag_measure.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lag_measure_pkg.sv
// Shared types and constants for the flash-to-sensor lag meter.
package lag_measure_pkg;

   localparam int LAG_W       = 17;
   localparam int BCD_W       = 20;
   localparam int CONV_CYCLES = 18;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      COUNTING = 2'd1,
      CONVERT  = 2'd2
   } state_t;

   typedef struct packed {
      logic [BCD_W-1:0] cur;
      logic [BCD_W-1:0] mn;
      logic [BCD_W-1:0] mx;
   } bcd_hold_t;

   // Double-dabble correction: any BCD digit of 5 or more gets +3 before the shift.
   function automatic logic [BCD_W-1:0] dabble_adj(input logic [BCD_W-1:0] b);
      logic [BCD_W-1:0] r;
      r = b;
      for (int i = 0; i < BCD_W/4; i++)
         if (r[4*i +: 4] >= 4'd5) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
      return r;
   endfunction

endpackage

// File: rtl/lag_measure_bin2bcd_seq.sv
// Sequential double-dabble converter: one load cycle then one shift per input bit.
module bin2bcd_seq
   import lag_measure_pkg::*;
(
   input  logic             clock,
   input  logic             rst,
   input  logic             start,
   input  logic [LAG_W-1:0] value,
   output logic             done,
   output logic [BCD_W-1:0] bcd
);

   logic [LAG_W-1:0] shreg;
   logic [4:0]       cnt;

   always_ff @(posedge clock) begin
      if (rst) begin
         shreg <= '0;
         cnt   <= '0;
         bcd   <= '0;
         done  <= 1'b0;
      end else if (start) begin
         // A new start always wins, even over a conversion still in flight.
         shreg <= value;
         bcd   <= '0;
         cnt   <= 5'(CONV_CYCLES - 1);
         done  <= 1'b0;
      end else if (cnt != 5'd0) begin
         {bcd, shreg} <= {dabble_adj(bcd), shreg} << 1;
         cnt          <= cnt - 5'd1;
         done         <= (cnt == 5'd1);
      end else begin
         done <= 1'b0;
      end
   end

endmodule

// File: rtl/lag_measure.sv
// Flash-to-sensor lag meter: 0.1 ms tick counter, min/max/average statistics,
// results presented as packed BCD through one shared sequential converter.
module lag_measure
   import lag_measure_pkg::*;
#(
   parameter int TICK_DIV    = 2700,
   parameter int AVG_SAMPLES = 16,
   parameter int LAG_MAX     = 99999
)(
   input  logic             clock,
   input  logic             rst,
   input  logic             reset_counter,
   input  logic             sensor_trigger,
   input  logic             reset_bcdoutput,
   output logic [BCD_W-1:0] bcd_current,
   output logic [BCD_W-1:0] bcd_minimum,
   output logic [BCD_W-1:0] bcd_maximum,
   output logic [BCD_W-1:0] bcd_average,
   output logic             avg_ready
);

   localparam int AVG_SH = $clog2(AVG_SAMPLES);
   localparam int SUM_W  = LAG_W + AVG_SH;
   localparam int PRE_W  = $clog2(TICK_DIV + 1);

   state_t            state;
   logic [PRE_W-1:0]  presc;
   logic [LAG_W-1:0]  lag_bin, sample, mn, mx, avg;
   logic [SUM_W-1:0]  sum, sum_next;
   logic [AVG_SH-1:0] cnt;
   logic              first, pending, avg_due, kick;
   logic [1:0]        idx, last_idx, next_idx;
   bcd_hold_t         hold;

   logic              conv_start, conv_done;
   logic [LAG_W-1:0]  conv_val;
   logic [BCD_W-1:0]  conv_bcd;

   // idx is the conversion in flight; a done pulse chains straight into the next one.
   always_comb begin
      last_idx   = avg_due ? 2'd3 : 2'd2;
      next_idx   = kick ? 2'd0 : 2'(idx + 2'd1);
      conv_start = (state == CONVERT) && (kick || (conv_done && idx != last_idx));
      sum_next   = sum + SUM_W'(lag_bin);
      case (next_idx)
         2'd0:    conv_val = sample;
         2'd1:    conv_val = mn;
         2'd2:    conv_val = mx;
         default: conv_val = avg;
      endcase
   end

   bin2bcd_seq u_conv (
      .clock (clock),
      .rst   (rst),
      .start (conv_start),
      .value (conv_val),
      .done  (conv_done),
      .bcd   (conv_bcd)
   );

   always_ff @(posedge clock) begin
      if (rst) begin
         state       <= IDLE;
         presc       <= '0;
         lag_bin     <= '0;
         sample      <= '0;
         mn          <= '0;
         mx          <= '0;
         avg         <= '0;
         sum         <= '0;
         cnt         <= '0;
         first       <= 1'b1;
         pending     <= 1'b0;
         avg_due     <= 1'b0;
         kick        <= 1'b0;
         idx         <= '0;
         hold        <= '0;
         bcd_current <= '0;
         bcd_minimum <= '0;
         bcd_maximum <= '0;
         bcd_average <= '0;
         avg_ready   <= 1'b0;
      end else begin
         avg_ready <= 1'b0;
         if (reset_bcdoutput) begin
            state       <= IDLE;
            mn          <= '0;
            mx          <= '0;
            avg         <= '0;
            sum         <= '0;
            cnt         <= '0;
            first       <= 1'b1;
            pending     <= 1'b0;
            avg_due     <= 1'b0;
            kick        <= 1'b0;
            bcd_current <= '0;
            bcd_minimum <= '0;
            bcd_maximum <= '0;
            bcd_average <= '0;
         end else begin
            case (state)
               IDLE: begin
                  if (reset_counter) begin
                     presc   <= '0;
                     lag_bin <= '0;
                     state   <= COUNTING;
                  end
               end
               COUNTING: begin
                  if (sensor_trigger) begin
                     sample  <= lag_bin;
                     mn      <= (first || lag_bin < mn) ? lag_bin : mn;
                     mx      <= (first || lag_bin > mx) ? lag_bin : mx;
                     first   <= 1'b0;
                     pending <= reset_counter;
                     kick    <= 1'b1;
                     idx     <= '0;
                     state   <= CONVERT;
                     if (cnt == AVG_SH'(AVG_SAMPLES - 1)) begin
                        avg     <= LAG_W'(sum_next >> AVG_SH);
                        sum     <= '0;
                        cnt     <= '0;
                        avg_due <= 1'b1;
                     end else begin
                        sum     <= sum_next;
                        cnt     <= cnt + AVG_SH'(1);
                        avg_due <= 1'b0;
                     end
                  end else if (reset_counter) begin
                     presc   <= '0;
                     lag_bin <= '0;
                  end else if (presc == PRE_W'(TICK_DIV - 1)) begin
                     presc <= '0;
                     if (lag_bin < LAG_W'(LAG_MAX)) lag_bin <= lag_bin + LAG_W'(1);
                  end else begin
                     presc <= presc + PRE_W'(1);
                  end
               end
               CONVERT: begin
                  kick <= 1'b0;
                  if (reset_counter) pending <= 1'b1;
                  if (!kick && conv_done) begin
                     case (idx)
                        2'd0:    hold.cur <= conv_bcd;
                        2'd1:    hold.mn  <= conv_bcd;
                        2'd2:    hold.mx  <= conv_bcd;
                        default: ;
                     endcase
                     if (idx == last_idx) begin
                        bcd_current <= hold.cur;
                        bcd_minimum <= hold.mn;
                        bcd_maximum <= (idx == 2'd2) ? conv_bcd : hold.mx;
                        if (avg_due) begin
                           bcd_average <= conv_bcd;
                           avg_ready   <= 1'b1;
                        end
                        avg_due <= 1'b0;
                        pending <= 1'b0;
                        if (pending || reset_counter) begin
                           presc   <= '0;
                           lag_bin <= '0;
                           state   <= COUNTING;
                        end else begin
                           state <= IDLE;
                        end
                     end else begin
                        idx <= 2'(idx + 2'd1);
                     end
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_lag_measure.sv
// Bench for lag_measure: timestamp-based reference model checked every cycle,
// plus literal expectations on the main, a saturation and a default-rate instance.
module tb_lag_measure;
   import lag_measure_pkg::*;

   localparam int TD   = 10;
   localparam int NAVG = 16;
   localparam int LMAX = 99999;

   logic clock = 1'b0;
   logic rst = 1'b1;
   logic rc = 1'b0, trig = 1'b0, rbo = 1'b0;
   logic [BCD_W-1:0] cur, mnv, mxv, avgv;
   logic rdy;

   logic s_rc = 1'b0, s_trig = 1'b0, s_rbo = 1'b0;
   logic [BCD_W-1:0] s_cur, s_min, s_max, s_avg;
   logic s_rdy;

   logic d_rc = 1'b0, d_trig = 1'b0, d_rbo = 1'b0;
   logic [BCD_W-1:0] d_cur, d_min, d_max, d_avg;
   logic d_rdy;

   logic c_start = 1'b0;
   logic [LAG_W-1:0] c_val = '0;
   logic c_done;
   logic [BCD_W-1:0] c_bcd;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   always #5 clock = ~clock;

   lag_measure #(.TICK_DIV(TD), .AVG_SAMPLES(NAVG), .LAG_MAX(LMAX)) dut (
      .clock(clock), .rst(rst), .reset_counter(rc), .sensor_trigger(trig),
      .reset_bcdoutput(rbo), .bcd_current(cur), .bcd_minimum(mnv),
      .bcd_maximum(mxv), .bcd_average(avgv), .avg_ready(rdy));

   lag_measure #(.TICK_DIV(2), .AVG_SAMPLES(2), .LAG_MAX(250)) dut_sat (
      .clock(clock), .rst(rst), .reset_counter(s_rc), .sensor_trigger(s_trig),
      .reset_bcdoutput(s_rbo), .bcd_current(s_cur), .bcd_minimum(s_min),
      .bcd_maximum(s_max), .bcd_average(s_avg), .avg_ready(s_rdy));

   lag_measure dut_def (
      .clock(clock), .rst(rst), .reset_counter(d_rc), .sensor_trigger(d_trig),
      .reset_bcdoutput(d_rbo), .bcd_current(d_cur), .bcd_minimum(d_min),
      .bcd_maximum(d_max), .bcd_average(d_avg), .avg_ready(d_rdy));

   bin2bcd_seq u_conv (
      .clock(clock), .rst(rst), .start(c_start), .value(c_val),
      .done(c_done), .bcd(c_bcd));

   function automatic logic [BCD_W-1:0] to_bcd(input int v);
      logic [BCD_W-1:0] r;
      int x;
      r = '0;
      x = v;
      for (int i = 0; i < 5; i++) begin
         r[4*i +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   // Reference model: lag = whole ticks between start and trigger, results appear after a fixed delay.
   int cyc = 0;
   bit m_count = 0, m_conv = 0, m_pend = 0, m_first = 1, m_avgdue = 0;
   int t_start = 0, t_upd = 0, lag = 0;
   int m_min = 0, m_max = 0, m_sum = 0, m_cnt = 0;
   int s_cur_v = 0, s_min_v = 0, s_max_v = 0, s_avg_v = 0;
   int e_cur = 0, e_min = 0, e_max = 0, e_avg = 0;
   bit e_rdy = 0;

   initial forever begin
      @(posedge clock);
      cyc++;
      e_rdy = 0;
      if (rst) begin
         m_count = 0; m_conv = 0; m_pend = 0; m_first = 1; m_avgdue = 0;
         m_min = 0; m_max = 0; m_sum = 0; m_cnt = 0;
         e_cur = 0; e_min = 0; e_max = 0; e_avg = 0;
      end else if (rbo) begin
         m_count = 0; m_conv = 0; m_pend = 0; m_first = 1; m_avgdue = 0;
         m_min = 0; m_max = 0; m_sum = 0; m_cnt = 0;
         e_cur = 0; e_min = 0; e_max = 0; e_avg = 0;
      end else if (m_conv) begin
         if (cyc == t_upd) begin
            e_cur = s_cur_v; e_min = s_min_v; e_max = s_max_v;
            if (m_avgdue) begin e_avg = s_avg_v; e_rdy = 1; end
            m_conv = 0;
            if (m_pend || rc) begin m_count = 1; t_start = cyc; end
            m_pend = 0;
         end else if (rc) m_pend = 1;
      end else if (m_count) begin
         if (trig) begin
            lag = (cyc - t_start - 1) / TD;
            if (lag > LMAX) lag = LMAX;
            if (m_first || lag < m_min) m_min = lag;
            if (m_first || lag > m_max) m_max = lag;
            m_first = 0;
            m_sum += lag;
            m_cnt++;
            m_avgdue = (m_cnt == NAVG);
            if (m_avgdue) begin s_avg_v = m_sum / NAVG; m_sum = 0; m_cnt = 0; end
            s_cur_v = lag; s_min_v = m_min; s_max_v = m_max;
            t_upd = cyc + (m_avgdue ? 73 : 55);
            m_conv = 1; m_count = 0; m_pend = rc;
         end else if (rc) t_start = cyc;
      end else if (rc) begin
         m_count = 1; t_start = cyc;
      end
   end

   initial forever begin
      @(negedge clock);
      if (chk_en) begin
         checks++;
         if (cur !== to_bcd(e_cur) || mnv !== to_bcd(e_min) || mxv !== to_bcd(e_max) ||
             avgv !== to_bcd(e_avg) || rdy !== e_rdy) begin
            errors++;
            $display("FAIL model_cmp t=%0t cur got %h exp %h min got %h exp %h max got %h exp %h avg got %h exp %h rdy got %b exp %b",
                     $time, cur, to_bcd(e_cur), mnv, to_bcd(e_min), mxv, to_bcd(e_max),
                     avgv, to_bcd(e_avg), rdy, e_rdy);
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", name, got, exp);
      end
   endtask

   // Start timing, then trigger k cycles after the start edge; returns just after the trigger edge.
   task automatic measure(input int k);
      rc = 1'b1; step(1); rc = 1'b0;
      step(k - 1);
      trig = 1'b1; step(1); trig = 1'b0;
   endtask

   task automatic pulse_trig();
      trig = 1'b1; step(1); trig = 1'b0;
   endtask

   task automatic pulse_rc();
      rc = 1'b1; step(1); rc = 1'b0;
   endtask

   task automatic pulse_rbo();
      rbo = 1'b1; step(1); rbo = 1'b0;
   endtask

   initial begin
      step(1);
      chk_en = 1'b1;
      step(2);
      rst = 1'b0;
      check("reset_cur", 32'(cur), 32'h0);
      check("reset_rdy", 32'(rdy), 32'h0);
      step(2);

      // Single measurement of 123 ticks and its exact latency.
      measure(1235);
      step(54);
      check("lat54_cur", 32'(cur), 32'h0);
      step(1);
      check("s1_cur", 32'(cur), 32'h00123);
      check("s1_min", 32'(mnv), 32'h00123);
      check("s1_max", 32'(mxv), 32'h00123);
      check("s1_avg", 32'(avgv), 32'h0);
      step(30);

      // Default-rate instance: 3 ticks of 2700 cycles.
      d_rc = 1'b1; step(1); d_rc = 1'b0;
      step(3 * 2700 + 4);
      d_trig = 1'b1; step(1); d_trig = 1'b0;
      step(54);
      check("def_lat54", 32'(d_cur), 32'h0);
      step(1);
      check("def_cur", 32'(d_cur), 32'h00003);
      check("def_min", 32'(d_min), 32'h00003);
      check("def_max", 32'(d_max), 32'h00003);
      check("def_avg", 32'(d_avg), 32'h0);
      check("def_rdy", 32'(d_rdy), 32'h0);

      rst = 1'b1; step(2); rst = 1'b0; step(2);
      check("rst2_min", 32'(mnv), 32'h0);

      // Sixteen samples 100..115 ticks.
      for (int i = 0; i < 16; i++) begin
         measure((100 + i) * TD + 5);
         if (i < 15) step(70);
      end
      step(72);
      check("avg_rdy_early", 32'(rdy), 32'h0);
      step(1);
      check("avg_rdy", 32'(rdy), 32'h1);
      check("avg1", 32'(avgv), 32'h00107);
      check("avg1_min", 32'(mnv), 32'h00100);
      check("avg1_max", 32'(mxv), 32'h00115);
      step(1);
      check("avg_rdy_once", 32'(rdy), 32'h0);
      step(10);

      // Next sixteen samples 10..25 ticks: 280/16 truncates to 17.
      for (int i = 0; i < 16; i++) begin
         measure((10 + i) * TD + 5);
         step(80);
      end
      check("avg2", 32'(avgv), 32'h00017);
      check("avg2_min", 32'(mnv), 32'h00010);
      check("avg2_max", 32'(mxv), 32'h00115);

      // Clear mid-COUNTING: later trigger ignored, next sample seeds min/max.
      pulse_rc();
      step(50);
      pulse_rbo();
      step(1);
      check("rbo_cur", 32'(cur), 32'h0);
      check("rbo_avg", 32'(avgv), 32'h0);
      pulse_trig();
      step(80);
      check("rbo_trig_ignored", 32'(cur), 32'h0);
      measure(40 * TD + 5);
      step(60);
      check("seed_cur", 32'(cur), 32'h00040);
      check("seed_min", 32'(mnv), 32'h00040);
      check("seed_max", 32'(mxv), 32'h00040);

      // Trigger while IDLE.
      pulse_trig();
      step(80);
      check("idle_trig", 32'(cur), 32'h00040);

      // Clear during CONVERT aborts the update.
      measure(20 * TD + 5);
      step(30);
      pulse_rbo();
      step(60);
      check("abort_cur", 32'(cur), 32'h0);
      check("abort_min", 32'(mnv), 32'h0);

      // Start coinciding with trigger is held pending.
      pulse_rc();
      step(50 * TD + 4);
      rc = 1'b1; trig = 1'b1; step(1); rc = 1'b0; trig = 1'b0;
      step(55);
      check("pend_cur50", 32'(cur), 32'h00050);
      step(304);
      pulse_trig();
      step(55);
      check("pend_cur30", 32'(cur), 32'h00030);
      check("pend_min", 32'(mnv), 32'h00030);
      check("pend_max", 32'(mxv), 32'h00050);
      step(20);

      // Two starts during CONVERT merge into one counting period.
      measure(60 * TD + 5);
      step(10);
      pulse_rc();
      step(5);
      pulse_rc();
      step(38);
      check("merge_cur60", 32'(cur), 32'h00060);
      step(204);
      pulse_trig();
      step(55);
      check("merge_cur20", 32'(cur), 32'h00020);
      pulse_trig();
      step(80);
      check("merge_single", 32'(cur), 32'h00020);

      // Saturation instance: 300 ticks clamps to 250; average of two samples.
      s_rc = 1'b1; step(1); s_rc = 1'b0;
      step(600);
      s_trig = 1'b1; step(1); s_trig = 1'b0;
      step(55);
      check("sat_cur", 32'(s_cur), 32'h00250);
      step(10);
      s_rc = 1'b1; step(1); s_rc = 1'b0;
      step(200);
      s_trig = 1'b1; step(1); s_trig = 1'b0;
      step(72);
      check("sat_rdy_early", 32'(s_rdy), 32'h0);
      step(1);
      check("sat_rdy", 32'(s_rdy), 32'h1);
      check("sat_avg", 32'(s_avg), 32'h00175);
      check("sat_min", 32'(s_min), 32'h00100);
      check("sat_max", 32'(s_max), 32'h00250);

      // Converter on the largest representable lag.
      c_val = 17'd99999;
      c_start = 1'b1; step(1); c_start = 1'b0;
      step(16);
      check("conv_done_early", 32'(c_done), 32'h0);
      step(1);
      check("conv_done", 32'(c_done), 32'h1);
      check("conv_99999", 32'(c_bcd), 32'h99999);

      step(5);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
